// File: rtl/vmem_arbiter.sv
// Round-robin arbiter for the shared data memory: scalar single-word accesses
// and 4-beat vector load/store sequences, with vector load data gathered into lane registers.
module vmem_arbiter #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              s_req,
   input  logic [ADDR_W-1:0] s_addr,
   input  logic [3:0]        s_we,
   input  logic [DATA_W-1:0] s_wdata,
   output logic              s_gnt,
   output logic              s_rvalid,
   output logic [DATA_W-1:0] s_rdata,
   input  logic              v_req,
   input  logic [3:0]        v_lsu_op,
   input  logic [ADDR_W-1:0] v_data_addr,
   input  logic [DATA_W-1:0] v_store_data_0,
   input  logic [DATA_W-1:0] v_store_data_1,
   input  logic [DATA_W-1:0] v_store_data_2,
   input  logic [DATA_W-1:0] v_store_data_3,
   output logic              v_gnt,
   output logic              v_done,
   output logic [DATA_W-1:0] v_load_data_0,
   output logic [DATA_W-1:0] v_load_data_1,
   output logic [DATA_W-1:0] v_load_data_2,
   output logic [DATA_W-1:0] v_load_data_3,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {ST_IDLE, ST_VEC, ST_VDRAIN} state_t;

   state_t                   r_state, w_next;
   logic [1:0]               r_beat;
   logic [3:0]               r_op;
   logic [ADDR_W-1:0]        r_base;
   logic [3:0][DATA_W-1:0]   r_sd;
   logic [3:0][DATA_W-1:0]   r_ld;
   logic                     r_vprio;     // 1: vector wins a tie (scalar was granted last)
   logic                     r_s_rvalid;

   logic                     w_idle, w_s_win, w_v_win;
   logic                     w_is_load, w_is_store, w_in_legal;
   logic [1:0]               w_shift;
   logic [ADDR_W-1:0]        w_vaddr;

   assign w_idle     = (r_state == ST_IDLE);
   assign w_s_win    = w_idle & s_req & (~v_req | ~r_vprio);
   assign w_v_win    = w_idle & v_req & (~s_req |  r_vprio);
   assign w_is_load  = (r_op[1:0] == 2'b01);
   assign w_is_store = (r_op[1:0] == 2'b10);
   assign w_in_legal = v_lsu_op[1] ^ v_lsu_op[0];

   // Strides are powers of two, so the beat offset is a shift; the sum wraps at 2^ADDR_W.
   always_comb begin
      w_shift = 2'd0;
      case (r_op[3:2])
         2'd1:    w_shift = 2'd1;
         2'd2:    w_shift = 2'd2;
         default: w_shift = 2'd0;
      endcase
   end
   assign w_vaddr = r_base + (ADDR_W'(r_beat) << w_shift);

   always_comb begin
      w_next    = r_state;
      s_gnt     = 1'b0;
      v_gnt     = 1'b0;
      v_done    = 1'b0;
      mem_addr  = '0;
      mem_we    = '0;
      mem_wdata = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_s_win) begin
               s_gnt     = 1'b1;
               mem_addr  = s_addr;
               mem_we    = s_we;
               mem_wdata = s_wdata;
            end else if (w_v_win) begin
               v_gnt  = 1'b1;
               w_next = w_in_legal ? ST_VEC : ST_VDRAIN;
            end
         end
         ST_VEC: begin
            mem_addr = w_vaddr;
            if (w_is_store) begin
               mem_we    = 4'hF;
               mem_wdata = r_sd[r_beat];
            end
            if (r_beat == 2'd3) w_next = ST_VDRAIN;
         end
         ST_VDRAIN: begin
            v_done = 1'b1;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state    <= ST_IDLE;
         r_beat     <= '0;
         r_op       <= '0;
         r_base     <= '0;
         r_sd       <= '0;
         r_ld       <= '0;
         r_vprio    <= 1'b0;
         r_s_rvalid <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_s_rvalid <= s_gnt & (s_we == 4'h0);
         if (s_gnt)      r_vprio <= 1'b1;
         else if (v_gnt) r_vprio <= 1'b0;
         if (v_gnt) begin
            r_op   <= v_lsu_op;
            r_base <= v_data_addr;
            r_sd   <= {v_store_data_3, v_store_data_2, v_store_data_1, v_store_data_0};
            r_beat <= '0;
         end
         // Read data trails its address by one cycle, so beat i returns lane i-1.
         if (r_state == ST_VEC) begin
            r_beat <= r_beat + 2'd1;
            if (w_is_load && r_beat != 2'd0) r_ld[r_beat - 2'd1] <= mem_rdata;
         end
         if (r_state == ST_VDRAIN && w_is_load) r_ld[3] <= mem_rdata;
      end
   end

   assign s_rvalid      = r_s_rvalid;
   assign s_rdata       = r_s_rvalid ? mem_rdata : '0;
   assign v_load_data_0 = r_ld[0];
   assign v_load_data_1 = r_ld[1];
   assign v_load_data_2 = r_ld[2];
   // Lane 3 is forwarded during the drain cycle so all lanes are valid alongside v_done.
   assign v_load_data_3 = (r_state == ST_VDRAIN && w_is_load) ? mem_rdata : r_ld[3];

endmodule

// File: tb/tb_vmem_arbiter.sv
// Bench for vmem_arbiter: synchronous-read memory model plus a transaction-level
// reference (expected memory image and lane values) driven by directed and random ops.
module tb_vmem_arbiter;

   localparam int AW = 14;
   localparam int DW = 32;
   localparam int MSZ = 16384;

   logic          clk, nrst;
   logic          s_req, s_gnt, s_rvalid;
   logic [AW-1:0] s_addr;
   logic [3:0]    s_we;
   logic [DW-1:0] s_wdata, s_rdata;
   logic          v_req, v_gnt, v_done;
   logic [3:0]    v_lsu_op;
   logic [AW-1:0] v_data_addr;
   logic [DW-1:0] v_sd0, v_sd1, v_sd2, v_sd3;
   logic [DW-1:0] v_ld0, v_ld1, v_ld2, v_ld3;
   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_we;
   logic [DW-1:0] mem_wdata, mem_rdata;

   bit   [31:0]        mem     [0:MSZ-1];
   bit   [31:0]        ref_mem [0:MSZ-1];
   logic [3:0][31:0]   exp_ld;
   int                 checks, errors;

   vmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .nrst(nrst),
      .s_req(s_req), .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata),
      .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
      .v_req(v_req), .v_lsu_op(v_lsu_op), .v_data_addr(v_data_addr),
      .v_store_data_0(v_sd0), .v_store_data_1(v_sd1),
      .v_store_data_2(v_sd2), .v_store_data_3(v_sd3),
      .v_gnt(v_gnt), .v_done(v_done),
      .v_load_data_0(v_ld0), .v_load_data_1(v_ld1),
      .v_load_data_2(v_ld2), .v_load_data_3(v_ld3),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-ported synchronous-read memory with byte enables.
   always @(posedge clk) begin
      mem_rdata <= mem[mem_addr];
      for (int b = 0; b < 4; b++)
         if (mem_we[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_lanes(input string tag);
      check({tag, "_lane0"}, v_ld0, exp_ld[0]);
      check({tag, "_lane1"}, v_ld1, exp_ld[1]);
      check({tag, "_lane2"}, v_ld2, exp_ld[2]);
      check({tag, "_lane3"}, v_ld3, exp_ld[3]);
   endtask

   function automatic int stride_of(input logic [1:0] code);
      return (code == 2'd1) ? 2 : (code == 2'd2) ? 4 : 1;
   endfunction

   task automatic scalar_op(input logic [AW-1:0] a, input logic [3:0] we, input logic [31:0] wd);
      @(negedge clk);
      v_req = 1'b0; s_req = 1'b1; s_addr = a; s_we = we; s_wdata = wd;
      #1;
      check("s_gnt", 32'(s_gnt), 32'd1);
      check("s_mem_addr", 32'(mem_addr), 32'(a));
      check("s_mem_we", 32'(mem_we), 32'(we));
      check("s_mem_wdata", mem_wdata, wd);
      @(negedge clk);
      s_req = 1'b0;
      #1;
      if (we == 4'h0) begin
         check("s_rvalid", 32'(s_rvalid), 32'd1);
         check("s_rdata", s_rdata, ref_mem[a]);
      end else begin
         check("s_rvalid_wr", 32'(s_rvalid), 32'd0);
         for (int b = 0; b < 4; b++)
            if (we[b]) ref_mem[a][b*8 +: 8] = wd[b*8 +: 8];
      end
   endtask

   task automatic vector_op(input logic [3:0] op, input logic [AW-1:0] base,
                            input logic [3:0][31:0] d);
      logic legal, is_load, is_store;
      int   a;
      legal    = op[1] ^ op[0];
      is_load  = (op[1:0] == 2'b01);
      is_store = (op[1:0] == 2'b10);
      @(negedge clk);
      s_req = 1'b0; v_req = 1'b1; v_lsu_op = op; v_data_addr = base;
      v_sd0 = d[0]; v_sd1 = d[1]; v_sd2 = d[2]; v_sd3 = d[3];
      #1;
      check("v_gnt", 32'(v_gnt), 32'd1);
      check("v_gnt_s_gnt", 32'(s_gnt), 32'd0);
      @(negedge clk);
      v_req = 1'b0;
      #1;
      if (legal) begin
         for (int i = 0; i < 4; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            a = (int'(base) + i * stride_of(op[3:2])) % MSZ;
            check("beat_addr", 32'(mem_addr), 32'(a));
            check("beat_we", 32'(mem_we), is_store ? 32'hF : 32'h0);
            check("beat_wdata", mem_wdata, is_store ? d[i] : 32'h0);
            check("beat_no_done", 32'(v_done), 32'd0);
            if (is_store) ref_mem[a] = d[i];
            if (is_load)  exp_ld[i] = ref_mem[a];
         end
         @(negedge clk); #1;
      end
      check("v_done", 32'(v_done), 32'd1);
      check("drain_we", 32'(mem_we), 32'd0);
      check("drain_addr", 32'(mem_addr), 32'd0);
      check_lanes("done");
      @(negedge clk); #1;
      check("v_done_pulse", 32'(v_done), 32'd0);
      check_lanes("held");
   endtask

   initial begin
      logic [3:0][31:0] d;
      logic [3:0]       op;
      logic [AW-1:0]    base, a;
      checks = 0; errors = 0;
      exp_ld = '0;
      nrst = 1'b0; s_req = 1'b0; s_addr = '0; s_we = '0; s_wdata = '0;
      v_req = 1'b0; v_lsu_op = '0; v_data_addr = '0;
      v_sd0 = '0; v_sd1 = '0; v_sd2 = '0; v_sd3 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      check("rst_s_gnt", 32'(s_gnt), 32'd0);
      check("rst_s_rvalid", 32'(s_rvalid), 32'd0);
      check("rst_s_rdata", s_rdata, 32'd0);
      check("rst_v_gnt", 32'(v_gnt), 32'd0);
      check("rst_v_done", 32'(v_done), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check_lanes("rst");
      nrst = 1'b1;

      // Contention straight out of reset: scalar first, then vector, then scalar at G+6.
      @(negedge clk);
      s_req = 1'b1; s_addr = 14'h0010; s_we = 4'h0;
      v_req = 1'b1; v_lsu_op = 4'b0001; v_data_addr = 14'h0200;
      #1;
      check("cont_s_first", 32'(s_gnt), 32'd1);
      check("cont_v_wait", 32'(v_gnt), 32'd0);
      @(negedge clk); #1;                       // G
      check("cont_v_gnt", 32'(v_gnt), 32'd1);
      check("cont_s_lose", 32'(s_gnt), 32'd0);
      check("cont_s_rvalid", 32'(s_rvalid), 32'd1);
      check("cont_s_rdata", s_rdata, ref_mem[16'h0010]);
      for (int i = 0; i < 4; i++) begin         // G+1..G+4
         @(negedge clk);
         v_req = 1'b0;
         #1;
         check("cont_s_blocked", 32'(s_gnt), 32'd0);
         exp_ld[i] = ref_mem[16'h0200 + i];
      end
      @(negedge clk); #1;                       // G+5
      check("cont_v_done", 32'(v_done), 32'd1);
      check("cont_s_blocked_drain", 32'(s_gnt), 32'd0);
      @(negedge clk); #1;                       // G+6
      check("cont_s_gnt_g6", 32'(s_gnt), 32'd1);
      check("cont_v_idle_g6", 32'(v_gnt), 32'd0);
      @(negedge clk);                           // both again: vector's turn
      s_addr = 14'h0011; v_req = 1'b1; v_lsu_op = 4'b0001; v_data_addr = 14'h0204;
      #1;
      check("cont_rr_v_gnt", 32'(v_gnt), 32'd1);
      check("cont_rr_s_lose", 32'(s_gnt), 32'd0);
      check("cont_rr_s_rvalid", 32'(s_rvalid), 32'd1);
      @(negedge clk);
      s_req = 1'b0; v_req = 1'b0;
      for (int i = 0; i < 4; i++) exp_ld[i] = ref_mem[16'h0204 + i];
      repeat (4) @(negedge clk);
      #1;
      check("cont_rr_v_done", 32'(v_done), 32'd1);
      check_lanes("cont_rr");

      // Scalar write then read back.
      scalar_op(14'h0010, 4'hF, 32'hDEADBEEF);
      scalar_op(14'h0010, 4'h0, 32'h0);
      check("wr_rd_const", s_rdata, 32'hDEADBEEF);

      // Unit-stride store then load.
      vector_op(4'b0010, 14'h0100, {32'h44, 32'h33, 32'h22, 32'h11});
      vector_op(4'b0001, 14'h0100, '0);
      check("unit_lane0_const", v_ld0, 32'h11);
      check("unit_lane3_const", v_ld3, 32'h44);

      // Stride 4 across the top of the address space.
      scalar_op(14'h3FF8, 4'hF, 32'hA0A0A0A0);
      scalar_op(14'h3FFC, 4'hF, 32'hB1B1B1B1);
      scalar_op(14'h0000, 4'hF, 32'hC2C2C2C2);
      scalar_op(14'h0004, 4'hF, 32'hD3D3D3D3);
      vector_op(4'b1001, 14'h3FF8, '0);
      check("wrap_lane2_const", v_ld2, 32'hC2C2C2C2);

      // Illegal ops: grant and done only, lanes untouched.
      vector_op(4'b0000, 14'h0123, {4{32'hFFFFFFFF}});
      vector_op(4'b1111, 14'h0456, {4{32'hEEEEEEEE}});

      // Randomized mix over a small address pool so accesses collide.
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 2))
            0: scalar_op(14'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), $urandom);
            1: scalar_op(14'($urandom_range(0, 31)), 4'h0, $urandom);
            default: begin
               op   = 4'($urandom_range(0, 15));
               base = ($urandom_range(0, 3) == 0) ? 14'(MSZ - $urandom_range(1, 12))
                                                  : 14'($urandom_range(0, 31));
               for (int i = 0; i < 4; i++) d[i] = $urandom;
               vector_op(op, base, d);
            end
         endcase
      end

      // Reset in the middle of a store burst.
      scalar_op(14'h0302, 4'hF, 32'h5A5A5A5A);
      for (int i = 0; i < 4; i++) d[i] = 32'hCAFE0000 + 32'(i);
      @(negedge clk);
      v_req = 1'b1; v_lsu_op = 4'b0010; v_data_addr = 14'h0300;
      v_sd0 = d[0]; v_sd1 = d[1]; v_sd2 = d[2]; v_sd3 = d[3];
      #1;
      check("rstb_v_gnt", 32'(v_gnt), 32'd1);
      @(negedge clk);
      v_req = 1'b0;
      repeat (2) @(negedge clk);                // now in beat 2
      #1;
      check("rstb_beat2_we", 32'(mem_we), 32'hF);
      check("rstb_beat2_addr", 32'(mem_addr), 32'h302);
      nrst = 1'b0;
      #1;
      check("rstb_we_zero", 32'(mem_we), 32'd0);
      check("rstb_addr_zero", 32'(mem_addr), 32'd0);
      check("rstb_wdata_zero", mem_wdata, 32'd0);
      check("rstb_no_done", 32'(v_done), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         check("rstb_hold_no_done", 32'(v_done), 32'd0);
      end
      nrst = 1'b1;
      ref_mem[14'h0300] = d[0];
      ref_mem[14'h0301] = d[1];
      exp_ld = '0;
      #1;
      check_lanes("rstb");
      @(negedge clk); #1;
      check("rstb_post_no_done", 32'(v_done), 32'd0);
      a = 14'h0300;
      scalar_op(a, 4'h0, 32'h0);
      scalar_op(a + 14'd1, 4'h0, 32'h0);
      scalar_op(a + 14'd2, 4'h0, 32'h0);
      check("rstb_beat2_unwritten", s_rdata, 32'h5A5A5A5A);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vmem_arbiter.md
# vmem_arbiter

Shared data-memory port arbiter and vector-access sequencer for the RV32IMC + Carrd vector coprocessor system. Two requesters share one single-ported, synchronous-read data memory: the scalar core LSU (single-word accesses) and the vector coprocessor LSU (4-lane loads/stores). The block grants requesters round-robin and serialises each vector operation into four back-to-back memory beats. It gathers the four vector load words into lane registers.

## Interface
Parameters
- ADDR_W, 14, word address width (matches vector data address)
- DATA_W, 32, memory word width

Ports
- clk  in  1  system clock; all state updates on rising edge
- nrst  in  1  reset, asynchronous, active-low
- s_req  in  1  scalar request; held with s_addr/s_we/s_wdata stable until s_gnt
- s_addr  in  ADDR_W  scalar word address
- s_we  in  4  scalar byte write enables (0 = read)
- s_wdata  in  DATA_W  scalar write data
- s_gnt  out  1  scalar access issued this cycle
- s_rvalid  out  1  s_rdata valid (cycle after s_gnt)
- s_rdata  out  DATA_W  scalar read data
- v_req  in  1  vector request; held with v_lsu_op/v_data_addr/store data stable until v_gnt
- v_lsu_op  in  4  [0]=load, [1]=store, [3:2]=stride code (0:1, 1:2, 2:4, 3:1)
- v_data_addr  in  ADDR_W  base word address, lane 0
- v_store_data_0..3  in  DATA_W each  lane store data
- v_gnt  out  1  vector op accepted (one-cycle pulse)
- v_done  out  1  vector op complete (one-cycle pulse)
- v_load_data_0..3  out  DATA_W each  lane load results, held until next vector load completes
- mem_addr  out  ADDR_W  memory address
- mem_we  out  4  memory byte write enables
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after address

## Operation
- States: IDLE, VEC (beat counter 0..3), VDRAIN.
- Arbitration happens only in IDLE.
  - If one requester is active, it wins.
  - If both are active, the side not granted last wins. The priority flag resets to favour scalar.
- Scalar grant:
  - s_gnt=1 in the same cycle.
  - mem_* are driven combinationally from s_addr/s_we/s_wdata.
  - The FSM stays in IDLE, so back-to-back scalar grants are allowed.
- Vector grant at cycle G:
  - v_gnt=1.
  - Op, base address and the four store words are latched.
  - Next state is VEC with beat=0.
- VEC beat i:
  - mem_addr = base + i*stride, modulo 2^ADDR_W (wraps).
  - Store: mem_we=4'hF, mem_wdata=lane i data.
  - Load: mem_we=0, and mem_rdata is captured into lane i-1 for beats 1..3.
  - After beat 3, next state is VDRAIN.
- VDRAIN:
  - Load: capture mem_rdata into lane 3.
  - v_done=1.
  - Memory outputs are idle.
  - Next state is IDLE.
- Illegal op (v_lsu_op[1:0] = 00 or 11): granted, no memory beats, goes straight to VDRAIN, lane registers unchanged.
- Idle memory outputs: mem_addr=0, mem_we=0, mem_wdata=0.
- s_req is ignored outside IDLE. v_req is ignored outside IDLE; the requester must keep holding it until v_gnt.

## Timing
- Reset values: s_gnt=0, s_rvalid=0, s_rdata=0, v_gnt=0, v_done=0, v_load_data_*=0, mem_*=0, state IDLE, priority=scalar.
- Scalar latency: s_gnt at G; s_rvalid=1 and s_rdata=mem_rdata at G+1 for reads only. Writes produce no s_rvalid.
- Vector latency (legal op):
  - v_gnt at G.
  - Beats at G+1..G+4.
  - v_done at G+5.
  - Load data is visible on v_load_data_* from G+5.
  - Total port occupancy: 5 cycles after grant.
- Vector latency (illegal op): v_done at G+1.
- Simultaneous s_req and v_req in IDLE: exactly one grant. The loser is granted at the next IDLE cycle.
- Scalar starvation bound: a scalar waiting behind a vector op is granted exactly at G+6.
- Reset asserted mid-burst:
  - Outputs zero immediately (asynchronous).
  - Already-issued store beats remain in memory.
  - No v_done is produced.
  - After release, the FSM is in IDLE.
- v_load_data_* update only on load beats/VDRAIN. Store ops leave them unchanged.

## Test plan
- Scalar write then read: write s_addr=0x0010, s_we=F, s_wdata=0xDEADBEEF; then read 0x0010 → s_gnt both cycles, s_rvalid at next cycle, s_rdata=0xDEADBEEF.
- Vector unit-stride store then load: base 0x0100, store data 0x11,0x22,0x33,0x44 → mem writes to 0x100..0x103 at G+1..G+4, v_done at G+5. A subsequent load returns lanes 0x11,0x22,0x33,0x44.
- Stride 4 with wrap: op=4'b1001 (load, stride 4), base 0x3FF8 → mem_addr sequence 0x3FF8, 0x3FFC, 0x0000, 0x0004.
- Contention: s_req and v_req asserted together from reset → s_gnt first. Next, v_gnt, with the scalar re-request waiting. After v_done the scalar is granted at G+6. When both request again, the vector is granted.
- Illegal op 4'b0000 → v_gnt, v_done one cycle later, mem_we stays 0, lane registers unchanged.
- Reset at beat 2 of a store → only beats 0-1 are written, outputs go to 0 immediately, no v_done. A fresh scalar read after release behaves normally.
